sram_req_ctrl: RTL

Initiator-side controller for the single-port registered-read SRAM macro interface (CLK, A, D, WEN, Q). It accepts read/write requests over a valid/ready channel, drives the SRAM address, data and bit-wise write-enable, and returns read data over a valid/ready response channel. It tolerates response back-pressure through a 2-entry response buffer and credit-limited issue. It sits between an LSU/IFU-style requester and one SRAM instance.

---
 rtl/sram_req_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/sram_req_ctrl.sv
// Initiator-side controller for a single-port registered-read SRAM macro.
// Issue is credit-limited so that a 2-entry buffer can absorb response back-pressure.
module sram_req_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] Q
);

    logic                  inflight;
    logic [1:0]            count;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [DATA_WIDTH-1:0] rsp_buf [2];

    logic                  fire;
    logic                  read_fire;
    logic                  write_fire;
    logic                  push;
    logic                  pop;
    logic [1:0]            credits_used;

    // Every outstanding read (on the SRAM or in the buffer) holds one of two credits.
    assign credits_used = {1'b0, inflight} + count;
    assign req_ready    = ~RST & (credits_used < 2'd2);

    assign fire       = req_valid & req_ready;
    assign read_fire  = fire & ~req_write;
    assign write_fire = fire & req_write;

    assign A   = fire ? req_addr : '0;
    assign D   = write_fire ? req_wdata : '0;
    assign WEN = write_fire ? req_wmask : '0;

    // Older buffered data always wins over the SRAM bypass to keep issue order.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        if (count != 2'd0) begin
            rsp_valid = 1'b1;
            rsp_rdata = rsp_buf[rd_ptr];
        end else if (inflight) begin
            rsp_valid = 1'b1;
            rsp_rdata = Q;
        end
    end

    assign push = inflight & ((count != 2'd0) | ~rsp_ready);
    assign pop  = (count != 2'd0) & rsp_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            inflight <= read_fire;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            rsp_buf[wr_ptr] <= Q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(push && count == 2'd2));
        end
    end

endmodule
